// File: rtl/ssd_score_scan.sv
// ssd_score_scan
//   Seven-segment display engine. A binary value captured on `load` is
//   converted to decimal (sequential double-dabble, one bit per cycle) or to
//   hex nibbles (one cycle). The result is committed atomically to the
//   display digit registers, so the scan never shows a half-converted value.
//   The digits are time-multiplexed onto one shared segment bus with
//   leading-zero blanking, a per-digit decimal point and an overflow dash
//   pattern.
//
// Ports
//   clk          system clock
//   btnCpuReset  asynchronous active-low reset
//   value        binary value to display (VALUE_W bits)
//   load         capture value/hex_mode when not busy
//   hex_mode     1 = hex digits, 0 = decimal (latched with load)
//   blank_lz     leading-zero blanking enable (live)
//   dp_mask      per-digit decimal point (live)
//   busy         conversion in progress
//   done         one-cycle pulse when the new digits take effect
//   overflow     committed value does not fit in DIGITS digits
//   anode        digit enables, bit 0 = rightmost digit
//   seg          segments, seg[6] = a ... seg[0] = g
//   dp           decimal point of the scanned digit
module ssd_score_scan #(
  parameter int DIGITS      = 8,
  parameter int VALUE_W     = 16,
  parameter int REFRESH_DIV = 100000,
  parameter bit ACTIVE_LOW  = 1'b1
) (
  input  logic               clk,
  input  logic               btnCpuReset,
  input  logic [VALUE_W-1:0] value,
  input  logic               load,
  input  logic               hex_mode,
  input  logic               blank_lz,
  input  logic [DIGITS-1:0]  dp_mask,
  output logic               busy,
  output logic               done,
  output logic               overflow,
  output logic [DIGITS-1:0]  anode,
  output logic [6:0]         seg,
  output logic               dp
);

  // Number of BCD digits needed for any VALUE_W-bit value; always at least
  // as many as the hex nibble count, so one result vector serves both modes.
  localparam int CD    = (VALUE_W * 3) / 10 + 1;
  localparam int DW    = CD * 4;
  localparam int CNT_W = $clog2(VALUE_W);
  localparam int REF_W = $clog2(REFRESH_DIV);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  // Glyphs are held active-low internally and flipped at the output register.
  localparam logic [6:0] SEG_DASH  = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [DIGITS-1:0] AN_OFF  = ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
  localparam logic [6:0]        SEG_OFF = ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic              DP_OFF  = ACTIVE_LOW;

  typedef enum logic {ST_IDLE, ST_CONV} state_t;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    g = SEG_BLANK;
    case (d)
      4'h0: g = 7'b0000001;
      4'h1: g = 7'b1001111;
      4'h2: g = 7'b0010010;
      4'h3: g = 7'b0000110;
      4'h4: g = 7'b1001100;
      4'h5: g = 7'b0100100;
      4'h6: g = 7'b0100000;
      4'h7: g = 7'b0001111;
      4'h8: g = 7'b0000000;
      4'h9: g = 7'b0000100;
      4'hA: g = 7'b0001000;
      4'hB: g = 7'b1100000;
      4'hC: g = 7'b0110001;
      4'hD: g = 7'b1000010;
      4'hE: g = 7'b0110000;
      4'hF: g = 7'b0111000;
      default: g = SEG_BLANK;
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------- state
  state_t               state_q, state_d;
  logic                 hex_q, hex_d;
  logic [VALUE_W-1:0]   bin_q, bin_d;
  logic [DW-1:0]        bcd_q, bcd_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [DIGITS*4-1:0]  disp_q, disp_d;
  logic                 ovf_q, ovf_d;
  logic                 done_q, done_d;
  logic [REF_W-1:0]     ref_q, ref_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DIGITS-1:0]    anode_q, anode_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;

  logic                 last_step;
  logic [DW-1:0]        bcd_adj;
  logic [DW-1:0]        bcd_step;
  logic [DW-1:0]        conv_res;
  logic [DIGITS*4-1:0]  conv_disp;
  logic [CD-1:0]        ovf_bits;
  logic                 conv_ovf;
  logic [3:0]           disp_dig [DIGITS];
  logic [DIGITS-1:0]    lz_mask;
  logic                 zero_run;
  logic                 cur_blank;
  logic [DIGITS-1:0]    an_on;
  logic [6:0]           seg_al;
  logic                 dp_on;

  // ----------------------------------------------------- conversion datapath
  // One double-dabble step: add 3 to every BCD digit >= 5, then shift the
  // next binary bit in from the bottom.
  genvar gi;
  generate
    for (gi = 0; gi < CD; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_q[gi*4 +: 4] >= 4'd5) ?
                                  bcd_q[gi*4 +: 4] + 4'd3 : bcd_q[gi*4 +: 4];
    end
  endgenerate

  assign bcd_step = {bcd_adj[DW-2:0], bin_q[VALUE_W-1]};
  assign conv_res = hex_q ? {{(DW-VALUE_W){1'b0}}, bin_q} : bcd_step;

  // Digits that land on the display; positions past the converter width
  // are always zero.
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_disp
      if (gi < CD) begin : g_src
        assign conv_disp[gi*4 +: 4] = conv_res[gi*4 +: 4];
      end else begin : g_zero
        assign conv_disp[gi*4 +: 4] = 4'd0;
      end
      assign disp_dig[gi] = disp_q[gi*4 +: 4];
    end
    // Any nonzero digit that has no display position means overflow.
    for (gi = 0; gi < CD; gi++) begin : g_ovf
      if (gi >= DIGITS) begin : g_chk
        assign ovf_bits[gi] = |conv_res[gi*4 +: 4];
      end else begin : g_none
        assign ovf_bits[gi] = 1'b0;
      end
    end
  endgenerate

  assign conv_ovf = |ovf_bits;

  // ------------------------------------------------------------------ FSM
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (load)      state_d = ST_CONV;
      ST_CONV: if (last_step) state_d = ST_IDLE;
      default:                state_d = ST_IDLE;
    endcase
  end

  // Hex needs a single cycle; decimal needs one cycle per input bit.
  always_comb begin
    busy      = 1'b0;
    last_step = 1'b0;
    if (state_q == ST_CONV) begin
      busy      = 1'b1;
      last_step = hex_q || (cnt_q == CNT_W'(VALUE_W - 1));
    end
  end

  // ------------------------------------------------------ converter / commit
  always_comb begin
    hex_d  = hex_q;
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    disp_d = disp_q;
    ovf_d  = ovf_q;
    done_d = 1'b0;
    if (state_q == ST_IDLE) begin
      if (load) begin
        hex_d = hex_mode;
        bin_d = value;
        bcd_d = '0;
        cnt_d = '0;
      end
    end else begin
      bin_d = bin_q << 1;
      bcd_d = bcd_step;
      cnt_d = cnt_q + 1'b1;
      // The final step's result goes straight into the display registers,
      // so the displayed digits switch in a single edge.
      if (last_step) begin
        disp_d = conv_disp;
        ovf_d  = conv_ovf;
        done_d = 1'b1;
      end
    end
  end

  // ------------------------------------------------------------------ scan
  always_comb begin
    ref_d = ref_q + 1'b1;
    idx_d = idx_q;
    if (ref_q == REF_W'(REFRESH_DIV - 1)) begin
      ref_d = '0;
      idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  // A digit is a leading zero when it and every digit above it are zero;
  // digit 0 is always shown.
  always_comb begin
    zero_run = 1'b1;
    lz_mask  = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (disp_dig[k] == 4'd0);
      if (k != 0) lz_mask[k] = zero_run;
    end
  end

  always_comb begin
    an_on     = '0;
    seg_al    = SEG_BLANK;
    dp_on     = 1'b0;
    cur_blank = blank_lz & ~ovf_q & lz_mask[idx_q];
    if (!cur_blank) begin
      an_on[idx_q] = 1'b1;
      seg_al       = ovf_q ? SEG_DASH : glyph(disp_dig[idx_q]);
      dp_on        = dp_mask[idx_q];
    end
    anode_d = ACTIVE_LOW ? ~an_on  : an_on;
    seg_d   = ACTIVE_LOW ? seg_al  : ~seg_al;
    dp_d    = ACTIVE_LOW ? ~dp_on  : dp_on;
  end

  // ------------------------------------------------------------ registers
  always_ff @(posedge clk or negedge btnCpuReset) begin
    if (!btnCpuReset) begin
      hex_q   <= 1'b0;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      disp_q  <= '0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
      ref_q   <= '0;
      idx_q   <= '0;
      anode_q <= AN_OFF;
      seg_q   <= SEG_OFF;
      dp_q    <= DP_OFF;
    end else begin
      hex_q   <= hex_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      disp_q  <= disp_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
      ref_q   <= ref_d;
      idx_q   <= idx_d;
      anode_q <= anode_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign done     = done_q;
  assign overflow = ovf_q;
  assign anode    = anode_q;
  assign seg      = seg_q;
  assign dp       = dp_q;

endmodule
